// File: rtl/ex_muldiv_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_if
// Request/response bundle between the ID/EX pipeline register and the
// iterative RV32M multiply/divide unit in EX.
//
// Request side  : req_valid, funct3, op_a, op_b, rd_in, flush
// Response side : stall, busy, result_valid, result, rd_out
//
// master : pipeline side (drives the request, observes stall and result)
// slave  : ex_muldiv_unit
// ----------------------------------------------------------------------------
interface ex_muldiv_if #(
   parameter int unsigned XLEN = 32
);
   logic            req_valid;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_in;
   logic            flush;

   logic            stall;
   logic            busy;
   logic            result_valid;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output req_valid, funct3, op_a, op_b, rd_in, flush,
      input  stall, busy, result_valid, result, rd_out
   );

   modport slave (
      input  req_valid, funct3, op_a, op_b, rd_in, flush,
      output stall, busy, result_valid, result, rd_out
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. Multiplies use a
// shift-add over a 64-bit accumulator, divides use a restoring divider with a
// 33-bit partial remainder; both retire one bit per cycle. Operands are
// processed as magnitudes and the sign is restored when the result is
// registered. While an operation is in flight the unit requests a pipeline
// stall; the result is presented with a one-cycle result_valid pulse.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : ex_muldiv_if.slave
//              in : req_valid, funct3, op_a, op_b, rd_in, flush
//              out: stall (combinational), busy (state decode),
//                   result_valid, result, rd_out (registered)
//
// Build option:
//   MULDIV_FAST_MUL_EN : when defined, funct3 0-3 use a single-cycle
//                        combinational 32x32 multiplier (IDLE -> DONE);
//                        divides keep the iterative path.
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   ex_muldiv_if.slave  bus
);

   localparam int unsigned PW = 2 * XLEN;       // product width
   localparam int unsigned CW = $clog2(XLEN);   // iteration counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   // Operation context captured at accept
   logic [2:0]      op_q;
   logic [4:0]      rd_q;
   logic            neg_q;       // negate product / quotient
   logic            neg_rem_q;   // negate remainder
   logic            div0_q;      // divisor was zero

   // Datapath
   logic [XLEN-1:0] opnd_q;      // multiplicand or divisor magnitude
   logic [PW-1:0]   acc_q;       // product accumulator; low half = dividend/quotient for divides
   logic [XLEN-1:0] rem_q;       // partial remainder (always below the divisor)
   logic [CW-1:0]   cnt_q;
   logic            last_q;      // all bits retired, next CALC edge registers the result

   // Outputs
   logic [XLEN-1:0] res_q;
   logic [4:0]      rd_out_q;
   logic            res_vld_q;

   // Accept-time operand conditioning
   logic            a_signed_c;
   logic            b_signed_c;
   logic            sa_c;
   logic            sb_c;
   logic [XLEN-1:0] mag_a_c;
   logic [XLEN-1:0] mag_b_c;
   logic            accept_c;
   logic            fast_c;

   // Iteration step
   logic [XLEN:0]   mul_sum_c;
   logic [PW-1:0]   mul_next_c;
   logic [XLEN:0]   div_shift_c;
   logic            div_borrow_c;
   logic [XLEN-1:0] div_diff_c;

   // Result formation
   logic [PW-1:0]   prod_c;
   logic [XLEN-1:0] quo_c;
   logic [XLEN-1:0] remv_c;
   logic [XLEN-1:0] calc_res_c;

   // Result select by funct3
   function automatic logic [XLEN-1:0] pick_result(
      input logic [2:0]      op,
      input logic [PW-1:0]   prod,
      input logic [XLEN-1:0] quo,
      input logic [XLEN-1:0] rem
   );
      logic [XLEN-1:0] r;
      unique case (op)
         3'd0:                  r = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3:      r = prod[PW-1:XLEN];
         3'd4, 3'd5:            r = quo;
         default:               r = rem;
      endcase
      return r;
   endfunction

   // Signedness per op: MULH both, MULHSU op_a only, DIV/REM both
   assign a_signed_c = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                       (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
   assign b_signed_c = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                       (bus.funct3 == 3'd6);
   assign sa_c       = a_signed_c & bus.op_a[XLEN-1];
   assign sb_c       = b_signed_c & bus.op_b[XLEN-1];
   assign mag_a_c    = sa_c ? (~bus.op_a + XLEN'(1)) : bus.op_a;
   assign mag_b_c    = sb_c ? (~bus.op_b + XLEN'(1)) : bus.op_b;

   assign accept_c   = (state_q == IDLE) && bus.req_valid && !bus.flush;

`ifdef MULDIV_FAST_MUL_EN
   logic [PW-1:0]   fast_mag_c;
   logic [PW-1:0]   fast_prod_c;
   logic [XLEN-1:0] fast_res_c;

   assign fast_c      = ~bus.funct3[2];
   assign fast_mag_c  = PW'(mag_a_c) * PW'(mag_b_c);
   assign fast_prod_c = (sa_c ^ sb_c) ? (~fast_mag_c + PW'(1)) : fast_mag_c;
   assign fast_res_c  = pick_result(bus.funct3, fast_prod_c, '0, '0);
`else
   assign fast_c      = 1'b0;
`endif

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit (acc_q[0]) is set, then shift the whole accumulator right.
   assign mul_sum_c    = {1'b0, acc_q[PW-1:XLEN]} +
                         (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
   assign mul_next_c   = {mul_sum_c, acc_q[XLEN-1:1]};

   // Restoring divide step: bring in the next dividend bit, trial-subtract.
   assign div_shift_c  = {rem_q, acc_q[XLEN-1]};
   assign div_borrow_c = div_shift_c < {1'b0, opnd_q};
   assign div_diff_c   = XLEN'(div_shift_c - {1'b0, opnd_q});

   // Sign correction and result select once all bits are retired.
   // A zero divisor yields all-ones quotient regardless of operand signs; the
   // remainder path already reproduces op_a in that case.
   assign prod_c     = neg_q ? (~acc_q + PW'(1)) : acc_q;
   assign quo_c      = div0_q ? {XLEN{1'b1}} :
                       (neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0]);
   assign remv_c     = neg_rem_q ? (~rem_q + XLEN'(1)) : rem_q;
   assign calc_res_c = pick_result(op_q, prod_c, quo_c, remv_c);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d = fast_c ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_q) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) begin
         state_d = IDLE;
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= '0;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         last_q    <= 1'b0;
         res_q     <= '0;
         rd_out_q  <= '0;
         res_vld_q <= 1'b0;
      end else begin
         res_vld_q <= 1'b0;
         if (accept_c) begin
            op_q      <= bus.funct3;
            rd_q      <= bus.rd_in;
            neg_q     <= sa_c ^ sb_c;
            neg_rem_q <= sa_c;
            div0_q    <= (bus.op_b == '0);
            rem_q     <= '0;
            cnt_q     <= CW'(XLEN - 1);
            last_q    <= 1'b0;
            if (bus.funct3[2]) begin
               opnd_q <= mag_b_c;
               acc_q  <= {XLEN'(0), mag_a_c};
            end else begin
               opnd_q <= mag_a_c;
               acc_q  <= {XLEN'(0), mag_b_c};
            end
`ifdef MULDIV_FAST_MUL_EN
            if (fast_c) begin
               res_q     <= fast_res_c;
               rd_out_q  <= bus.rd_in;
               res_vld_q <= 1'b1;
            end
`endif
         end else if ((state_q == CALC) && !bus.flush) begin
            if (last_q) begin
               res_q     <= calc_res_c;
               rd_out_q  <= rd_q;
               res_vld_q <= 1'b1;
            end else begin
               if (op_q[2]) begin
                  acc_q[XLEN-1:0] <= {acc_q[XLEN-2:0], ~div_borrow_c};
                  rem_q           <= div_borrow_c ? div_shift_c[XLEN-1:0] : div_diff_c;
               end else begin
                  acc_q <= mul_next_c;
               end
               if (cnt_q == '0) begin
                  last_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
         end
      end
   end

   // Stall is combinational so the front end holds in the accept cycle
   assign bus.stall        = accept_c || (state_q == CALC);
   assign bus.busy         = (state_q != IDLE);
   assign bus.result_valid = res_vld_q;
   assign bus.result       = res_q;
   assign bus.rd_out       = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush and
// reset aborts, and randomized operations against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] last_exp = 32'h0;

   ex_muldiv_if #(.XLEN(32)) bus ();

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: RV32M semantics from plain signed/unsigned arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] p;
      longint      la;
      longint      lb;
      int          sa;
      int          sb;
      logic [31:0] r;
      sa = a;
      sb = b;
      la = longint'(sa);
      lb = longint'(sb);
      case (f)
         3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
         3'd1: begin p = la * lb; r = p[63:32]; end
         3'd2: begin p = la * longint'({32'h0, b}); r = p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 32'h0)                                   r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else                                              r = sa / sb;
         end
         3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0)                                   r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else                                              r = sa % sb;
         end
         default: r = (b == 32'h0) ? a : a % b;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for its accept cycle only
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      bus.req_valid = 1'b1;
      bus.funct3    = f;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.rd_in     = rd;
      #1;
   endtask

   // Full operation: accept, wait bounded for the pulse, check timing and value
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      int          lat;
      int          stall_n;
      logic [31:0] exp;
      exp = ref_model(f, a, b);
      start_op(f, a, b, rd);
      chk({tag, "_stall_accept"}, 32'(bus.stall), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      lat     = 0;
      stall_n = 0;
      while (!bus.result_valid && lat < 60) begin
         if (bus.stall && bus.busy) stall_n++;
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd33);
      chk({tag, "_stall_cycles"}, 32'(stall_n), 32'd33);
      chk({tag, "_result"}, bus.result, exp);
      chk({tag, "_rd"}, 32'(bus.rd_out), 32'(rd));
      chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
      last_exp = exp;
      tick();
      chk({tag, "_pulse_end"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int          pulses;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;

      bus.req_valid = 1'b0;
      bus.funct3    = 3'd0;
      bus.op_a      = 32'h0;
      bus.op_b      = 32'h0;
      bus.rd_in     = 5'd0;
      bus.flush     = 1'b0;
      reset         = 1'b1;
      #1;
      chk("rst_stall",  32'(bus.stall), 32'd0);
      chk("rst_busy",   32'(bus.busy), 32'd0);
      chk("rst_valid",  32'(bus.result_valid), 32'd0);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_rd",     32'(bus.rd_out), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Directed cases
      run_op("mul",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1);
      chk("mul_const", last_exp, 32'hFFFF_FFEB);
      run_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      chk("mulhu_const", last_exp, 32'hFFFF_FFFE);
      run_op("mulh",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4);
      run_op("div",      3'd4, 32'hFFFF_FFEC, 32'h0000_0006, 5'd5);
      chk("div_const", last_exp, 32'hFFFF_FFFD);
      run_op("rem",      3'd6, 32'hFFFF_FFEC, 32'h0000_0006, 5'd6);
      run_op("divu",     3'd5, 32'd100, 32'd7, 5'd7);
      run_op("remu",     3'd7, 32'd100, 32'd7, 5'd8);
      run_op("div0",     3'd4, 32'd5, 32'd0, 5'd9);
      run_op("rem0",     3'd6, 32'd5, 32'd0, 5'd10);
      run_op("divneg0",  3'd4, 32'hFFFF_FFFB, 32'd0, 5'd11);
      run_op("divovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      run_op("removf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

      // Flush 10 cycles into a DIVU
      start_op(3'd5, 32'd1000, 32'd3, 5'd14);
      tick();
      bus.req_valid = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      chk("flush_busy",   32'(bus.busy), 32'd0);
      chk("flush_stall",  32'(bus.stall), 32'd0);
      chk("flush_valid",  32'(bus.result_valid), 32'd0);
      chk("flush_result", bus.result, last_exp);
      run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd15);
      chk("mul_after_flush_const", last_exp, 32'd12);

      // Flush and request together in IDLE: flush wins
      start_op(3'd0, 32'd2, 32'd2, 5'd16);
      bus.flush = 1'b1;
      #1;
      chk("flushreq_stall", 32'(bus.stall), 32'd0);
      tick();
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk("flushreq_busy", 32'(bus.busy), 32'd0);

      // Reset 5 cycles into a DIV
      start_op(3'd4, 32'hFFFF_FF00, 32'd7, 5'd17);
      tick();
      bus.req_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      #1;
      chk("rstmid_busy",   32'(bus.busy), 32'd0);
      chk("rstmid_stall",  32'(bus.stall), 32'd0);
      chk("rstmid_valid",  32'(bus.result_valid), 32'd0);
      chk("rstmid_result", bus.result, 32'h0);
      chk("rstmid_rd",     32'(bus.rd_out), 32'd0);
      tick();
      tick();
      reset  = 1'b0;
      pulses = 0;
      repeat (40) begin
         tick();
         if (bus.result_valid) pulses++;
      end
      chk("rstmid_no_pulse", 32'(pulses), 32'd0);

      // Randomized operations with corner-biased operands
      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
            3: b = 32'(-int'($urandom_range(1, 50)));
            default: ;
         endcase
         run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, 5'($urandom_range(0, 31)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
